// File: rtl/div_freq_ctrl_pkg.sv
// Shared types and constants for the divider-sharing arbiter.
package div_freq_ctrl_pkg;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned RESET_RATIO = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_GRANT   = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

endpackage

// File: rtl/div_freq_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_c,
    output logic [IW-1:0]   idx_c,
    output logic            valid_c
);

    always_comb begin
        int unsigned j;
        logic        found;
        j       = 0;
        found   = 1'b0;
        gnt_c   = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req[IW'(j)]) begin
                found           = 1'b1;
                gnt_c[IW'(j)]   = 1'b1;
                idx_c           = IW'(j);
                valid_c         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_freq_ctrl.sv
// Shares one frequency divider among NREQ requesters: round-robin pick, program, settle, grant.
// Optional grant timeout with requester masking: define DIV_FREQ_CTRL_TIMEOUT_EN.
module div_freq_ctrl
    import div_freq_ctrl_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] ratio,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  err,
    output logic [WIDTH-1:0]      div_din,
    output logic                  div_conf,
    output logic                  div_enable
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    if (NREQ < 2 || NREQ > 8 || SETTLE < 1 || TIMEOUT < 1) begin : g_param_check
        $error("div_freq_ctrl: parameter out of range");
    end

    state_t           state_q, state_d;
    logic [IW-1:0]    win_q, win_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] cache_q, cache_d;
    logic [SW-1:0]    scnt_q, scnt_d;
    logic             drop_q, drop_d;
    logic [NREQ-1:0]  gnt_d;
    logic             busy_d, err_d, conf_d;
    logic [WIDTH-1:0] din_d;

    logic [WIDTH-1:0] ratio_a [NREQ];
    logic [WIDTH-1:0] sel_ratio;
    logic [NREQ-1:0]  req_elig;
    logic [NREQ-1:0]  pick_oh;
    logic [IW-1:0]    pick_idx;
    logic             pick_vld;
    logic [NREQ-1:0]  win_oh;

`ifdef DIV_FREQ_CTRL_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [NREQ-1:0] mask_q, mask_d;
    assign req_elig = req & ~mask_q;
`else
    assign req_elig = req;
`endif

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            ratio_a[i] = ratio[i*WIDTH +: WIDTH];
        end
    end

    assign sel_ratio = ratio_a[pick_idx];
    assign win_oh    = NREQ'(1) << win_q;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req     (req_elig),
        .ptr     (ptr_q),
        .gnt_c   (pick_oh),
        .idx_c   (pick_idx),
        .valid_c (pick_vld)
    );

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (32'(i) == NREQ - 1) ? '0 : i + IW'(1);
    endfunction

    // Next-state and next-output decode; a winner dropping req mid-programming is remembered in drop.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        cache_d = cache_q;
        scnt_d  = scnt_q;
        drop_d  = drop_q;
        gnt_d   = gnt;
        err_d   = 1'b0;
        din_d   = div_din;
        conf_d  = 1'b0;
`ifdef DIV_FREQ_CTRL_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        mask_d  = mask_q & req;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    win_d = pick_idx;
                    if (sel_ratio == '0) begin
                        err_d = 1'b1;
                        ptr_d = next_idx(pick_idx);
                    end else if (sel_ratio == cache_q) begin
                        state_d = ST_GRANT;
                        gnt_d   = pick_oh;
`ifdef DIV_FREQ_CTRL_TIMEOUT_EN
                        tcnt_d  = '0;
`endif
                    end else begin
                        state_d = ST_LOAD;
                        din_d   = sel_ratio;
                        cache_d = sel_ratio;
                        conf_d  = 1'b1;
                        drop_d  = 1'b0;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_SETTLE;
                scnt_d  = '0;
                drop_d  = ~req[win_q];
            end
            ST_SETTLE: begin
                drop_d = drop_q | ~req[win_q];
                if (scnt_q == SW'(SETTLE - 1)) begin
                    if (drop_d) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_GRANT;
                        gnt_d   = win_oh;
`ifdef DIV_FREQ_CTRL_TIMEOUT_EN
                        tcnt_d  = '0;
`endif
                    end
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            ST_GRANT: begin
                if (!req[win_q]) begin
                    state_d = ST_RELEASE;
                    gnt_d   = '0;
                end
`ifdef DIV_FREQ_CTRL_TIMEOUT_EN
                else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    state_d       = ST_RELEASE;
                    gnt_d         = '0;
                    err_d         = 1'b1;
                    mask_d[win_q] = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
`endif
            end
            ST_RELEASE: begin
                ptr_d   = next_idx(win_q);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            win_q      <= '0;
            ptr_q      <= '0;
            cache_q    <= WIDTH'(RESET_RATIO);
            scnt_q     <= '0;
            drop_q     <= 1'b0;
            gnt        <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
            div_din    <= WIDTH'(RESET_RATIO);
            div_conf   <= 1'b0;
            div_enable <= 1'b0;
`ifdef DIV_FREQ_CTRL_TIMEOUT_EN
            tcnt_q     <= '0;
            mask_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            ptr_q      <= ptr_d;
            cache_q    <= cache_d;
            scnt_q     <= scnt_d;
            drop_q     <= drop_d;
            gnt        <= gnt_d;
            busy       <= busy_d;
            err        <= err_d;
            div_din    <= din_d;
            div_conf   <= conf_d;
            div_enable <= 1'b0;
`ifdef DIV_FREQ_CTRL_TIMEOUT_EN
            tcnt_q     <= tcnt_d;
            mask_q     <= mask_d;
`endif
        end
    end

endmodule

// File: tb/tb_div_freq_ctrl.sv
// Bench for div_freq_ctrl: directed table, corner sequences, random rounds vs a transaction-level model.
module tb_div_freq_ctrl;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 8;
    localparam int          LOAD_LAT = SETTLE + 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] ratio;
    logic [NREQ-1:0]       gnt;
    logic                  busy, err, div_conf, div_enable;
    logic [WIDTH-1:0]      div_din;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_freq_ctrl #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .ratio      (ratio),
        .gnt        (gnt),
        .busy       (busy),
        .err        (err),
        .div_din    (div_din),
        .div_conf   (div_conf),
        .div_enable (div_enable)
    );

    typedef struct {
        logic [3:0]   rq;
        logic [127:0] rt;
        int           w;
        bit           e_err;
        int           e_lat;
        bit           e_conf;
        logic [31:0]  e_din;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [127:0] pack4(input logic [31:0] r0, input logic [31:0] r1,
                                           input logic [31:0] r2, input logic [31:0] r3);
        return {r3, r2, r1, r0};
    endfunction

    function automatic vec_t mk(input logic [3:0] rq, input logic [127:0] rt, input int w,
                                input bit e, input int lat, input bit c, input logic [31:0] d);
        vec_t v;
        v.rq = rq; v.rt = rt; v.w = w; v.e_err = e; v.e_lat = lat; v.e_conf = c; v.e_din = d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One arbitration from an IDLE cycle: expect a grant to w (or an err pulse) after e_lat cycles.
    task automatic run_txn(input int w, input bit e_err, input int e_lat, input bit e_conf,
                           input logic [31:0] e_din, input logic [3:0] drop);
        int          k, confs, h;
        bit          hit, hold_ok;
        logic [31:0] din_seen, din_g;
        logic [3:0]  e_gnt;
        k = 0; confs = 0; hit = 1'b0; din_seen = '0;
        e_gnt = e_err ? 4'b0000 : (4'b0001 << w);
        while (!hit && k < 40) begin
            @(negedge clk);
            k++;
            if (div_conf) begin
                confs++;
                din_seen = div_din;
            end
            if (gnt != 4'b0000 || err) hit = 1'b1;
        end
        chk("event_seen", 64'(hit), 64'(1));
        chk("latency", 64'(k), 64'(e_lat));
        chk("gnt", 64'(gnt), 64'(e_gnt));
        chk("err", 64'(err), 64'(e_err));
        chk("conf_count", 64'(confs), 64'(e_conf));
        if (e_conf) chk("div_din", 64'(din_seen), 64'(e_din));
        chk("div_enable", 64'(div_enable), 64'(0));
        if (e_err) begin
            req = req & ~drop;
            return;
        end
        h = $urandom_range(2, 4);
        hold_ok = 1'b1;
        din_g = div_din;
        for (int i = 1; i < h; i++) begin
            ratio[w*WIDTH +: WIDTH] = $urandom;
            @(negedge clk);
            if (gnt !== e_gnt || div_conf !== 1'b0 || div_din !== din_g || busy !== 1'b1)
                hold_ok = 1'b0;
        end
        chk("hold_stable", 64'(hold_ok), 64'(1));
        req = req & ~drop;
        @(negedge clk);
        chk("release_gnt", 64'(gnt), 64'(0));
        chk("release_busy", 64'(busy), 64'(1));
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'(0));
    endtask

    function automatic int rr_pick(input logic [3:0] live, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (live[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int          confs, gseen, ptr_m, w;
        logic [31:0] cache_m, r;
        logic [3:0]  live, m;
        int unsigned vals [4];
        vals = '{0, 2, 3, 5};

        // Directed table; expectations start from reset pointer 0 and cached ratio 1.
        tbl[0] = mk(4'b0001, pack4(6, 0, 0, 0), 0, 1'b0, LOAD_LAT, 1'b1, 32'd6);
        tbl[1] = mk(4'b0100, pack4(0, 0, 6, 0), 2, 1'b0, 1,        1'b0, 32'd0);
        tbl[2] = mk(4'b0010, pack4(0, 0, 0, 0), 1, 1'b1, 1,        1'b0, 32'd0);
        tbl[3] = mk(4'b1000, pack4(0, 0, 0, 5), 3, 1'b0, LOAD_LAT, 1'b1, 32'd5);
        tbl[4] = mk(4'b0001, pack4(1, 0, 0, 0), 0, 1'b0, LOAD_LAT, 1'b1, 32'd1);
        tbl[5] = mk(4'b0011, pack4(9, 1, 0, 0), 1, 1'b0, 1,        1'b0, 32'd0);
        tbl[6] = mk(4'b0001, pack4(0, 0, 0, 0), 0, 1'b1, 1,        1'b0, 32'd0);
        tbl[7] = mk(4'b1111, pack4(2, 2, 2, 2), 1, 1'b0, LOAD_LAT, 1'b1, 32'd2);
        tbl[8] = mk(4'b0101, pack4(2, 7, 2, 7), 2, 1'b0, 1,        1'b0, 32'd0);

        reset = 1'b1; req = '0; ratio = '0;
        #1 reset = 1'b0;
        #2;
        chk("rst_gnt", 64'(gnt), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_conf", 64'(div_conf), 64'(0));
        chk("rst_enable", 64'(div_enable), 64'(0));
        chk("rst_din", 64'(div_din), 64'(1));
        @(negedge clk) reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            req   = tbl[i].rq;
            ratio = tbl[i].rt;
            run_txn(tbl[i].w, tbl[i].e_err, tbl[i].e_lat, tbl[i].e_conf, tbl[i].e_din, 4'b1111);
        end

        // Winner drops req during SETTLE: divider still programmed, no grant, ratio 4 now cached.
        req = 4'b0001; ratio = pack4(4, 0, 0, 0);
        confs = 0; gseen = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i == 2) req = 4'b0000;
            if (div_conf) confs++;
            if (gnt != 4'b0000) gseen++;
        end
        chk("drop_conf", 64'(confs), 64'(1));
        chk("drop_no_gnt", 64'(gseen), 64'(0));
        chk("drop_idle", 64'(busy), 64'(0));
        req = 4'b0100; ratio = pack4(0, 0, 4, 0);
        run_txn(2, 1'b0, 1, 1'b0, 32'd0, 4'b1111);

        // Reset mid-SETTLE: outputs return at once; afterwards pointer 0 and cached ratio 1.
        req = 4'b0100; ratio = pack4(0, 0, 7, 0);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'(1));
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_gnt", 64'(gnt), 64'(0));
        chk("mid_rst_din", 64'(div_din), 64'(1));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_conf", 64'(div_conf), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        req = 4'b1010; ratio = pack4(0, 1, 0, 1);
        run_txn(1, 1'b0, 1, 1'b0, 32'd0, 4'b1111);

`ifdef DIV_FREQ_CTRL_TIMEOUT_EN
        // Held grant is revoked after TIMEOUT cycles and not re-issued until req toggles.
        req = 4'b0001; ratio = pack4(1, 0, 0, 0);
        confs = 0; gseen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (gnt == 4'b0001) gseen++;
            if (err) confs++;
        end
        chk("to_gnt_cycles", 64'(gseen), 64'(TIMEOUT));
        chk("to_err_pulses", 64'(confs), 64'(1));
        req = 4'b0000;
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        chk("to_regrant", 64'(gnt), 64'(1));
        req = 4'b0000;
        repeat (2) @(negedge clk);
        chk("to_idle", 64'(busy), 64'(0));
`endif

        // Random rounds against the transaction-level model.
        @(negedge clk) reset = 1'b0;
        req = '0;
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        ptr_m = 0;
        cache_m = 32'd1;
        for (int rnd = 0; rnd < 40; rnd++) begin
            live = (rnd == 0) ? 4'b1111 : 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                ratio[i*WIDTH +: WIDTH] = (rnd == 0) ? 32'(i + 2) : 32'(vals[$urandom_range(0, 3)]);
            end
            req = live;
            while (live != 4'b0000) begin
                w = rr_pick(live, ptr_m);
                m = 4'b0001 << w;
                r = ratio[w*WIDTH +: WIDTH];
                if (r == 32'd0) begin
                    run_txn(w, 1'b1, 1, 1'b0, 32'd0, m);
                end else if (r == cache_m) begin
                    run_txn(w, 1'b0, 1, 1'b0, 32'd0, m);
                end else begin
                    run_txn(w, 1'b0, LOAD_LAT, 1'b1, r, m);
                    cache_m = r;
                end
                ptr_m = (w + 1) % NREQ;
                live = live & ~m;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
